// File: rtl/booth_mul_ctrl.sv
// Sequencing controller for a radix-16 Booth multiplier datapath.
// Issues one load, N_DIGITS partial-product steps, then holds the result until the consumer takes it.
module booth_mul_ctrl #(
    parameter int unsigned N_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       dp_load,
    output logic       dp_step,
    output logic [3:0] dp_digit_idx,
    output logic       dp_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and state-decoded outputs; only in_ready looks at inputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_ready     = 1'b0;
        dp_load      = 1'b0;
        dp_step      = 1'b0;
        dp_digit_idx = '0;
        dp_last      = 1'b0;
        out_valid    = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                in_ready = !abort;
                if (in_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dp_load = 1'b1;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                dp_step      = 1'b1;
                dp_digit_idx = cnt_q;
                dp_last      = (cnt_q == LAST_IDX);
                // Counter is parked at zero on exit so it never passes the last digit.
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !abort;
                if (out_ready) begin
                    state_d = in_valid ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: three instances (8, 2 and 15 digits) share one stimulus stream.
module tb_booth_mul_ctrl;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic abort;

    logic       in_ready_w  [3];
    logic       dp_load_w   [3];
    logic       dp_step_w   [3];
    logic       dp_last_w   [3];
    logic       out_valid_w [3];
    logic       busy_w      [3];
    logic [3:0] idx_w       [3];
    logic [9:0] obs         [3];

    int nd [3] = '{8, 2, 15};
    int t  [3];
    int checks   = 0;
    int failures = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned ND = (g == 0) ? 8 : ((g == 1) ? 2 : 15);
            booth_mul_ctrl #(.N_DIGITS(ND)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .in_valid     (in_valid),
                .in_ready     (in_ready_w[g]),
                .abort        (abort),
                .dp_load      (dp_load_w[g]),
                .dp_step      (dp_step_w[g]),
                .dp_digit_idx (idx_w[g]),
                .dp_last      (dp_last_w[g]),
                .out_valid    (out_valid_w[g]),
                .out_ready    (out_ready),
                .busy         (busy_w[g])
            );
            assign obs[g] = {in_ready_w[g], dp_load_w[g], dp_step_w[g], dp_last_w[g],
                             out_valid_w[g], busy_w[g], idx_w[g]};
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: t counts cycles since the accept (0 = idle, N+2 = result held).
    function automatic int next_t(int tc, int n, logic iv, logic ordy, logic ab);
        if (ab) return 0;
        if (tc == 0) return iv ? 1 : 0;
        if (tc < n + 2) return tc + 1;
        if (ordy) return iv ? 1 : 0;
        return tc;
    endfunction

    function automatic logic [9:0] expect_obs(int tc, int n, logic ordy, logic ab);
        logic st;
        st = (tc >= 2) && (tc <= n + 1);
        return {(!ab) && ((tc == 0) || ((tc == n + 2) && ordy)), tc == 1, st, tc == n + 1,
                tc == n + 2, tc != 0, st ? 4'(tc - 2) : 4'd0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) t[k] <= 0;
            else        t[k] <= next_t(t[k], nd[k], in_valid, out_ready, abort);
        end
    end

    task automatic idle_cycles(input int n);
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 10'b1_0_0_0_0_0_0000) begin
                failures++;
                $display("FAIL reset inst=%0d got=%b exp=%b", k, obs[k], 10'b1000000000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single operation on all three widths: exact cycle-by-cycle timeline.
    task automatic test_single();
        logic [9:0] exp_v;
        int n;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                n = nd[k];
                exp_v = {c > n + 1, c == 1, (c >= 2) && (c <= n + 1), c == n + 1, c == n + 2,
                         c <= n + 2, ((c >= 2) && (c <= n + 1)) ? 4'(c - 2) : 4'd0};
                checks++;
                if (obs[k] !== exp_v) begin
                    failures++;
                    $display("FAIL single inst=%0d cyc=%0d got=%b exp=%b", k, c, obs[k], exp_v);
                end
            end
        end
        idle_cycles(5);
    endtask

    task automatic test_backpressure();
        logic [2:0] got, exp_v;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = (c >= 15);
            #1;
            got   = {out_valid_w[0], in_ready_w[0], busy_w[0]};
            exp_v = {(c >= 10) && (c <= 15), c >= 15, c <= 15};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got=%b exp=%b", c, got, exp_v);
            end
        end
        idle_cycles(20);
    endtask

    task automatic test_back_to_back();
        logic [1:0] got, exp_v;
        int p;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                p     = nd[k] + 2;
                got   = {in_ready_w[k], dp_load_w[k]};
                exp_v = {(c % p) == 0, (c % p) == 1};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL back_to_back inst=%0d cyc=%0d got=%b exp=%b", k, c, got, exp_v);
                end
            end
        end
        idle_cycles(20);
    endtask

    task automatic test_abort();
        logic ov_seen [3];
        for (int k = 0; k < 3; k++) ov_seen[k] = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            abort    = (c == 5);
            #1;
            if (c == 5) begin
                checks++;
                if ({dp_step_w[0], idx_w[0]} !== 5'b1_0011) begin
                    failures++;
                    $display("FAIL abort_idx got=%b exp=%b", {dp_step_w[0], idx_w[0]}, 5'b10011);
                end
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (in_ready_w[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL abort_in_ready inst=%0d got=%b exp=0", k, in_ready_w[k]);
                    end
                end
            end
            if (c == 6) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (busy_w[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL abort_busy inst=%0d got=%b exp=0", k, busy_w[k]);
                    end
                end
            end
            if (c >= 6) begin
                for (int k = 0; k < 3; k++) ov_seen[k] = ov_seen[k] | out_valid_w[k];
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov_seen[k] !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_out_valid inst=%0d got=%b exp=0", k, ov_seen[k]);
            end
        end
        idle_cycles(5);
    endtask

    task automatic test_async_reset();
        int first_ov [3];
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 10'b1000000000) begin
                failures++;
                $display("FAIL async_reset inst=%0d got=%b exp=%b", k, obs[k], 10'b1000000000);
            end
            first_ov[k] = -1;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                if (c == 1) begin
                    checks++;
                    if (dp_load_w[k] !== 1'b1) begin
                        failures++;
                        $display("FAIL post_reset_load inst=%0d got=%b exp=1", k, dp_load_w[k]);
                    end
                end
                if (out_valid_w[k] === 1'b1 && first_ov[k] < 0) first_ov[k] = c;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (first_ov[k] != nd[k] + 2) begin
                failures++;
                $display("FAIL post_reset_latency inst=%0d got=%0d exp=%0d", k, first_ov[k], nd[k] + 2);
            end
        end
        idle_cycles(5);
    endtask

    // Random inputs, including aborts and asynchronous resets, against the reference model.
    task automatic test_random();
        logic [9:0] exp_v;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(99) == 0) rst_n = 1'b0;
            in_valid  = 1'($urandom_range(1));
            out_ready = ($urandom_range(9) < 7);
            abort     = ($urandom_range(19) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_v = expect_obs(t[k], nd[k], out_ready, abort);
                checks++;
                if (obs[k] !== exp_v) begin
                    failures++;
                    $display("FAIL random inst=%0d cyc=%0d got=%b exp=%b", k, c, obs[k], exp_v);
                end
            end
        end
        rst_n = 1'b1;
        idle_cycles(20);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        abort     = 1'b0;
        test_reset();
        idle_cycles(2);
        test_single();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
